// File: rtl/uncached_store_buffer.sv
// Posted-write FIFO for uncached stores: accepts a store per cycle, drains in order
// with one outstanding bus write, and flags loads that alias a pending store.
module uncached_store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [ADDR_WIDTH-1:0]        push_paddr,
    input  logic [DATA_WIDTH-1:0]        push_wrdata,
    input  logic [DATA_WIDTH/8-1:0]      push_be,
    input  logic [ADDR_WIDTH-1:0]        query_paddr,
    output logic                         query_hit,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [ADDR_WIDTH-1:0]        mem_paddr,
    output logic [DATA_WIDTH-1:0]        mem_wrdata,
    output logic [DATA_WIDTH/8-1:0]      mem_be,
    input  logic                         mem_resp_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] paddr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [BE_W-1:0]       be_q    [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic             push_fire, pop;

    assign push_ready = (count != CNT_W'(DEPTH));
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_fire  = push_valid && push_ready;
    assign pop        = (state == WAIT_ACK) && mem_resp_valid;

    assign mem_paddr  = paddr_q[head];
    assign mem_wrdata = data_q[head];
    assign mem_be     = be_q[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The ack of the last entry returns to IDLE even if a store arrives that cycle; IDLE picks it up next.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (count != '0) state_next = REQ;
            REQ:      if (mem_req_ready) state_next = WAIT_ACK;
            WAIT_ACK: if (mem_resp_valid) state_next = (count != CNT_W'(1)) ? REQ : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = (state == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_fire) tail <= tail + PTR_W'(1);
            if (pop)       head <= head + PTR_W'(1);
            case ({push_fire, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            paddr_q[tail] <= push_paddr;
            data_q[tail]  <= push_wrdata;
            be_q[tail]    <= push_be;
        end
    end

    // An entry is live when its distance from head is below count; this covers the in-flight head too.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset    = '0;
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - head;
            if ((CNT_W'(offset) < count) &&
                (paddr_q[i][ADDR_WIDTH-1:2] == query_paddr[ADDR_WIDTH-1:2])) begin
                query_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uncached_store_buffer.sv
// Directed bench for uncached_store_buffer: single store, fill/refuse, full-with-ack,
// address query, reset while in flight, and a 20-store streaming run.
module tb_uncached_store_buffer;

    logic        clk;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_paddr;
    logic [31:0] push_wrdata;
    logic [3:0]  push_be;
    logic [31:0] query_paddr;
    logic        query_hit;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_paddr;
    logic [31:0] mem_wrdata;
    logic [3:0]  mem_be;
    logic        mem_resp_valid;

    int vectors;
    int miscompares;

    uncached_store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_paddr(push_paddr), .push_wrdata(push_wrdata), .push_be(push_be),
        .query_paddr(query_paddr), .query_hit(query_hit),
        .empty(empty), .full(full), .count(count),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_paddr(mem_paddr), .mem_wrdata(mem_wrdata), .mem_be(mem_be),
        .mem_resp_valid(mem_resp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a bus request, captures it, then accepts and acknowledges it.
    task automatic serve_one(output logic [31:0] a, output logic [31:0] d, output bit timeout);
        int n;
        n = 0;
        a = '0;
        d = '0;
        timeout = 1'b0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req_valid) begin
            timeout = 1'b1;
            return;
        end
        a = mem_paddr;
        d = mem_wrdata;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic push_n(input logic [31:0] base, input logic [31:0] dbase, input int n);
        for (int i = 0; i < n; i++) begin
            push_valid  = 1'b1;
            push_paddr  = base + 32'(4 * i);
            push_wrdata = dbase + 32'(i);
            push_be     = 4'hf;
            tick();
        end
        push_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0 || push_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got empty=%b full=%b ready=%b want 1 0 1", empty, full, push_ready);
        end
        vectors++;
        if (mem_req_valid !== 1'b0 || query_hit !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got req=%b hit=%b want 0 0", mem_req_valid, query_hit);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_store();
        mem_req_ready = 1'b1;
        push_valid  = 1'b1;
        push_paddr  = 32'h1fd0f000;
        push_wrdata = 32'h11;
        push_be     = 4'hf;
        tick();
        push_valid = 1'b0;
        vectors++;
        if (count !== 3'd1 || empty !== 1'b0 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_after_push: got count=%0d empty=%b req=%b want 1 0 0", count, empty, mem_req_valid);
        end
        tick();
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_paddr !== 32'h1fd0f000 || mem_wrdata !== 32'h11 || mem_be !== 4'hf) begin
            miscompares++;
            $display("[TB] FAIL single_req: got req=%b a=%h d=%h be=%h want 1 1fd0f000 00000011 f",
                     mem_req_valid, mem_paddr, mem_wrdata, mem_be);
        end
        tick();
        mem_req_ready = 1'b0;
        vectors++;
        if (mem_req_valid !== 1'b0 || count !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL single_wait: got req=%b count=%0d want 0 1", mem_req_valid, count);
        end
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        vectors++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_done: got count=%0d empty=%b want 0 1", count, empty);
        end
        tick();
    endtask

    task automatic test_fill_and_order();
        logic [31:0] a, d;
        bit to;
        push_n(32'h00001000, 32'h000000b0, 4);
        vectors++;
        if (count !== 3'd4 || full !== 1'b1 || push_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fill_full: got count=%0d full=%b ready=%b want 4 1 0", count, full, push_ready);
        end
        push_valid = 1'b1;
        push_paddr = 32'h00002000;
        tick();
        push_valid = 1'b0;
        vectors++;
        if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL fill_refuse: got count=%0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            serve_one(a, d, to);
            vectors++;
            if (to || a !== 32'h00001000 + 32'(4 * i) || d !== 32'h000000b0 + 32'(i)) begin
                miscompares++;
                $display("[TB] FAIL fill_order[%0d]: got a=%h d=%h timeout=%0d want a=%h d=%h", i, a, d, to,
                         32'h00001000 + 32'(4 * i), 32'h000000b0 + 32'(i));
            end
        end
        vectors++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fill_drained: got count=%0d empty=%b want 0 1", count, empty);
        end
        tick();
    endtask

    task automatic test_full_ack_push();
        logic [31:0] a, d;
        logic [31:0] exp_a [4];
        bit to;
        exp_a = '{32'h00003004, 32'h00003008, 32'h0000300c, 32'h00003100};
        push_n(32'h00003000, 32'h000000c0, 4);
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        push_valid  = 1'b1;
        push_paddr  = 32'h00003100;
        push_wrdata = 32'h000000ce;
        tick();
        mem_resp_valid = 1'b0;
        vectors++;
        if (count !== 3'd3 || push_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fullack_refused: got count=%0d ready=%b want 3 1", count, push_ready);
        end
        tick();
        push_valid = 1'b0;
        vectors++;
        if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL fullack_retry: got count=%0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            serve_one(a, d, to);
            vectors++;
            if (to || a !== exp_a[i]) begin
                miscompares++;
                $display("[TB] FAIL fullack_order[%0d]: got a=%h timeout=%0d want %h", i, a, to, exp_a[i]);
            end
        end
        vectors++;
        if (d !== 32'h000000ce) begin miscompares++; $display("[TB] FAIL fullack_data: got %h want 000000ce", d); end
        tick();
    endtask

    task automatic test_query();
        logic [31:0] a, d;
        bit to;
        push_valid  = 1'b1;
        push_paddr  = 32'h1faf0004;
        push_wrdata = 32'h44;
        push_be     = 4'h1;
        query_paddr = 32'h1faf0006;
        #1;
        vectors++;
        if (query_hit !== 1'b0) begin miscompares++; $display("[TB] FAIL query_same_cycle: got %b want 0", query_hit); end
        tick();
        push_valid = 1'b0;
        #1;
        vectors++;
        if (query_hit !== 1'b1) begin miscompares++; $display("[TB] FAIL query_hit_word: got %b want 1", query_hit); end
        query_paddr = 32'h1faf0008;
        #1;
        vectors++;
        if (query_hit !== 1'b0) begin miscompares++; $display("[TB] FAIL query_next_word: got %b want 0", query_hit); end
        query_paddr = 32'h1faf0006;
        tick();
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        vectors++;
        if (query_hit !== 1'b1) begin miscompares++; $display("[TB] FAIL query_in_flight: got %b want 1", query_hit); end
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        vectors++;
        if (query_hit !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL query_after_ack: got hit=%b count=%0d want 0 0", query_hit, count);
        end
        serve_one(a, d, to);
        vectors++;
        if (to !== 1'b1) begin miscompares++; $display("[TB] FAIL query_no_extra_req: got a=%h want no request", a); end
        query_paddr = '0;
    endtask

    task automatic test_reset_in_flight();
        push_n(32'h00004000, 32'h000000d0, 3);
        query_paddr = 32'h00004004;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        vectors++;
        if (query_hit !== 1'b1 || count !== 3'd3 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstfl_pre: got hit=%b count=%0d req=%b want 1 3 0", query_hit, count, mem_req_valid);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (count !== 3'd0 || mem_req_valid !== 1'b0 || query_hit !== 1'b0 || empty !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstfl_async: got count=%0d req=%b hit=%b empty=%b want 0 0 0 1",
                     count, mem_req_valid, query_hit, empty);
        end
        tick();
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        vectors++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstfl_late_ack: got count=%0d empty=%b want 0 1", count, empty);
        end
        tick();
        vectors++;
        if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstfl_idle: got req=%b want 0", mem_req_valid); end
        query_paddr = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] obs_a [20];
        logic [31:0] obs_d [20];
        int got;
        for (int i = 0; i < 20; i++) begin
            obs_a[i] = '0;
            obs_d[i] = '0;
        end
        got = 0;
        mem_req_ready = 1'b1;
        fork
            begin
                int cyc;
                cyc = 0;
                for (int i = 0; i < 20 && cyc < 600; ) begin
                    bit accepted;
                    push_valid  = 1'b1;
                    push_paddr  = 32'h20000000 + 32'(4 * i);
                    push_wrdata = 32'ha5000000 + 32'(i);
                    push_be     = 4'hf;
                    accepted = push_ready;
                    tick();
                    cyc++;
                    if (accepted) i++;
                end
                push_valid = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while (got < 20 && cyc < 800) begin
                    vectors++;
                    if (count > 3'd4) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_count_bound: got count=%0d want <= 4", count);
                    end
                    if (mem_req_valid) begin
                        obs_a[got] = mem_paddr;
                        obs_d[got] = mem_wrdata;
                        got++;
                        tick();
                        mem_resp_valid = 1'b1;
                        tick();
                        mem_resp_valid = 1'b0;
                        cyc += 2;
                    end else begin
                        tick();
                        cyc++;
                    end
                end
            end
        join
        mem_req_ready = 1'b0;
        vectors++;
        if (got != 20) begin miscompares++; $display("[TB] FAIL b2b_total: got %0d stores want 20", got); end
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (obs_a[i] !== 32'h20000000 + 32'(4 * i) || obs_d[i] !== 32'ha5000000 + 32'(i)) begin
                miscompares++;
                $display("[TB] FAIL b2b_order[%0d]: got a=%h d=%h want a=%h d=%h", i, obs_a[i], obs_d[i],
                         32'h20000000 + 32'(4 * i), 32'ha5000000 + 32'(i));
            end
        end
        tick();
        vectors++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_drained: got count=%0d empty=%b want 0 1", count, empty);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        push_valid     = 1'b0;
        push_paddr     = '0;
        push_wrdata    = '0;
        push_be        = '0;
        query_paddr    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        test_reset();
        test_single_store();
        test_fill_and_order();
        test_full_ack_push();
        test_query();
        test_reset_in_flight();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
